// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared types and constants for the round-robin mux scan controller.
package mux_scan_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    // Starting from 7 makes channel 0 the first one searched after reset.
    localparam logic [SEL_W-1:0] PTR_RST = 3'd7;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SETTLE = 2'b01,
        HOLD   = 2'b10
    } state_t;

endpackage

// File: rtl/rr_pick8.sv
// rr_pick8: combinational round-robin picker, first set request after i_ptr (wrapping).
module rr_pick8
    import mux_scan_pkg::*;
(
    input  logic [NCH-1:0]   i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic             o_any,
    output logic [SEL_W-1:0] o_idx
);

    // Walk from farthest to nearest so the nearest set bit after i_ptr wins.
    always_comb begin
        o_any = |i_req;
        o_idx = i_ptr;
        for (int k = NCH; k >= 1; k--)
            if (i_req[i_ptr + SEL_W'(k)])
                o_idx = i_ptr + SEL_W'(k);
    end

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: round-robin scan of an 8:1 enabled byte mux, capturing the selected
// byte after a settle window and presenting it with its channel on valid/ready.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SETTLE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [NCH-1:0]   i_req,
    output logic [NCH-1:0]   o_ack,
    output logic [SEL_W-1:0] o_sel,
    output logic             o_enable,
    input  logic [WIDTH-1:0] i_mux_data,
    output logic [WIDTH-1:0] o_data_out,
    output logic [SEL_W-1:0] o_chan_out,
    output logic             o_valid,
    input  logic             i_ready
);

    localparam logic [NCH-1:0] ONE_HOT0 = NCH'(1);

    state_t           r_state, w_next;
    logic [3:0]       r_cnt;
    logic [SEL_W-1:0] r_ptr, r_sel, r_chan;
    logic [NCH-1:0]   r_ack;
    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             w_any, w_grant, w_cap, w_hs;
    logic [SEL_W-1:0] w_idx;

    rr_pick8 u_pick (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_any (w_any),
        .o_idx (w_idx)
    );

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n)
            r_state <= mux_scan_pkg::IDLE;
        else
            r_state <= w_next;

    always_comb begin
        w_next   = r_state;
        w_grant  = 1'b0;
        w_cap    = 1'b0;
        w_hs     = 1'b0;
        o_enable = 1'b0;
        case (r_state)
            mux_scan_pkg::IDLE: begin
                w_grant = w_any;
                w_next  = w_any ? mux_scan_pkg::SETTLE : mux_scan_pkg::IDLE;
            end
            mux_scan_pkg::SETTLE: begin
                o_enable = 1'b1;
                w_cap    = r_cnt == 4'(SETTLE - 1);
                w_next   = w_cap ? mux_scan_pkg::HOLD : mux_scan_pkg::SETTLE;
            end
            mux_scan_pkg::HOLD: begin
                w_hs   = r_valid & i_ready;
                w_next = w_hs ? mux_scan_pkg::IDLE : mux_scan_pkg::HOLD;
            end
            default: w_next = mux_scan_pkg::IDLE;
        endcase
    end

    // Mux_data is only sampled on the capture edge, never while the mux is disabled.
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            r_sel   <= '0;
            r_cnt   <= '0;
            r_ptr   <= PTR_RST;
            r_ack   <= '0;
            r_data  <= '0;
            r_chan  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_ack <= '0;
            if (w_grant) begin
                r_sel <= w_idx;
                r_cnt <= '0;
            end
            if (r_state == mux_scan_pkg::SETTLE)
                r_cnt <= r_cnt + 4'd1;
            if (w_cap) begin
                r_data  <= i_mux_data;
                r_chan  <= r_sel;
                r_valid <= 1'b1;
                r_ack   <= ONE_HOT0 << r_sel;
                r_ptr   <= r_sel;
            end
            if (w_hs)
                r_valid <= 1'b0;
        end

    assign o_sel      = r_sel;
    assign o_ack      = r_ack;
    assign o_data_out = r_data;
    assign o_chan_out = r_chan;
    assign o_valid    = r_valid;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: scoreboard bench for two controllers (SETTLE=1 and SETTLE=3)
// sharing clock and reset, each driving its own behavioural 8:1 mux.
module tb_mux_scan_ctrl;

    typedef struct packed {
        logic [2:0] chan;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req   [2];
    logic       ready [2];
    logic [7:0] ack   [2];
    logic [2:0] sel   [2];
    logic       en    [2];
    logic [7:0] mux   [2];
    logic [7:0] dout  [2];
    logic [2:0] chan  [2];
    logic       valid [2];
    logic [7:0] mem   [2][8];
    exp_t       q     [2][$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural mux: a junk value while disabled exposes captures outside SETTLE.
    assign mux[0] = en[0] ? mem[0][sel[0]] : 8'hEE;
    assign mux[1] = en[1] ? mem[1][sel[1]] : 8'hEE;

    mux_scan_ctrl #(.WIDTH(8), .SETTLE(1)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req[0]), .o_ack(ack[0]),
        .o_sel(sel[0]), .o_enable(en[0]), .i_mux_data(mux[0]),
        .o_data_out(dout[0]), .o_chan_out(chan[0]), .o_valid(valid[0]),
        .i_ready(ready[0])
    );

    mux_scan_ctrl #(.WIDTH(8), .SETTLE(3)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req[1]), .o_ack(ack[1]),
        .o_sel(sel[1]), .o_enable(en[1]), .i_mux_data(mux[1]),
        .o_data_out(dout[1]), .o_chan_out(chan[1]), .o_valid(valid[1]),
        .i_ready(ready[1])
    );

    function automatic int settle_of(input int d);
        return d == 0 ? 1 : 3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_byte(input int d, input logic [2:0] c);
        q[d].push_back(exp_t'({c, mem[d][c]}));
    endtask

    task automatic wait_en(input int d, input string name);
        int n = 0;
        @(negedge clk);
        while (!en[d] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: enable never rose on dut%0d", name, d);
        end
    endtask

    task automatic wait_ack(input int d, input string name);
        int n = 0;
        @(negedge clk);
        while (ack[d] == 8'h00 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: ack never pulsed on dut%0d", name, d);
        end
    endtask

    task automatic wait_idle(input int d, input string name);
        int n = 0;
        @(negedge clk);
        while ((q[d].size() != 0 || valid[d]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL timeout_%s: dut%0d pending %0d bytes", name, d, q[d].size());
        end
    endtask

    // Reset is held across a falling edge so the monitor also sees it.
    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: pops one expected byte on the first Valid cycle, then checks the
    // held byte, Sel and Ack quiet for the rest of the HOLD.
    initial begin
        logic       seen   [2];
        int         en_cnt [2];
        logic [7:0] hdata  [2];
        logic [2:0] hchan  [2];
        exp_t       e;
        seen   = '{1'b0, 1'b0};
        en_cnt = '{0, 0};
        hdata  = '{8'h00, 8'h00};
        hchan  = '{3'd0, 3'd0};
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    seen[d]   = 1'b0;
                    en_cnt[d] = 0;
                end else begin
                    if (en[d]) begin
                        chk("valid_during_enable", 32'(valid[d]), 0);
                        en_cnt[d]++;
                    end
                    if (valid[d] && !seen[d]) begin
                        if (q[d].size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_byte: dut%0d chan %0d data %0h", d, chan[d], dout[d]);
                        end else begin
                            e = q[d].pop_front();
                            chk("chan_out", 32'(chan[d]), 32'(e.chan));
                            chk("data_out", 32'(dout[d]), 32'(e.data));
                            chk("ack_pulse", 32'(ack[d]), 32'(8'd1 << e.chan));
                            chk("enable_cycles", en_cnt[d], settle_of(d));
                        end
                        en_cnt[d] = 0;
                        hdata[d]  = dout[d];
                        hchan[d]  = chan[d];
                        seen[d]   = 1'b1;
                    end else if (valid[d]) begin
                        chk("ack_after_first", 32'(ack[d]), 0);
                        chk("data_held", 32'(dout[d]), 32'(hdata[d]));
                        chk("chan_held", 32'(chan[d]), 32'(hchan[d]));
                        chk("sel_held", 32'(sel[d]), 32'(hchan[d]));
                    end else begin
                        chk("ack_without_valid", 32'(ack[d]), 0);
                    end
                    if (valid[d] && ready[d])
                        seen[d] = 1'b0;
                end
            end
        end
    end

    initial begin
        int t0;
        int t1;
        rst_n = 1'b0;
        req   = '{8'h00, 8'h00};
        ready = '{1'b1, 1'b1};
        for (int i = 0; i < 8; i++) begin
            mem[0][i] = 8'h20 + 8'(i);
            mem[1][i] = 8'h50 + 8'(i);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_sel", 32'(sel[d]), 0);
            chk("rst_enable", 32'(en[d]), 0);
            chk("rst_valid", 32'(valid[d]), 0);
            chk("rst_ack", 32'(ack[d]), 0);
            chk("rst_data", 32'(dout[d]), 0);
            chk("rst_chan", 32'(chan[d]), 0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset asserted while Enable is high clears everything asynchronously.
        req[0] = 8'h04;
        wait_en(0, "mid_settle");
        #2 rst_n = 1'b0;
        #1;
        chk("async_enable", 32'(en[0]), 0);
        chk("async_valid", 32'(valid[0]), 0);
        chk("async_ack", 32'(ack[0]), 0);
        chk("async_sel", 32'(sel[0]), 0);
        chk("async_data", 32'(dout[0]), 0);
        expect_byte(0, 3'd2);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ack(0, "after_reset");
        req[0] = 8'h00;
        wait_idle(0, "after_reset");

        // Single request captured from a known mux value.
        do_reset();
        mem[0][0] = 8'hA5;
        expect_byte(0, 3'd0);
        req[0] = 8'h01;
        wait_ack(0, "single");
        req[0] = 8'h00;
        wait_idle(0, "single");

        // All channels requesting: strict rotation, one byte every three cycles.
        do_reset();
        for (int i = 0; i < 8; i++) expect_byte(0, 3'(i));
        expect_byte(0, 3'd0);
        req[0] = 8'hFF;
        t0 = 0;
        t1 = 0;
        for (int n = 0; n < 9; n++) begin
            wait_ack(0, "fair");
            if (n == 0) t0 = cyc;
            t1 = cyc;
        end
        req[0] = 8'h00;
        chk("fair_period", t1 - t0, 24);
        wait_idle(0, "fair");

        // Request withdrawn during SETTLE is still captured.
        mem[0][4] = 8'h3C;
        expect_byte(0, 3'd4);
        @(posedge clk);
        #1 req[0] = 8'h10;
        wait_en(0, "drop");
        req[0] = 8'h00;
        wait_idle(0, "drop");

        // Backpressure on the SETTLE=3 instance, then channel 7 in turn.
        @(posedge clk);
        #1 ready[1] = 1'b0;
        expect_byte(1, 3'd0);
        expect_byte(1, 3'd7);
        req[1] = 8'h81;
        wait_ack(1, "bp_first");
        req[1] = 8'h80;
        repeat (10) begin
            @(negedge clk);
            chk("bp_valid", 32'(valid[1]), 1);
            chk("bp_enable", 32'(en[1]), 0);
        end
        @(posedge clk);
        #1 ready[1] = 1'b1;
        wait_ack(1, "bp_second");
        req[1] = 8'h00;
        wait_idle(1, "bp_second");

        chk("queue0_drained", q[0].size(), 0);
        chk("queue1_drained", q[1].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
